// File: rtl/hex_fetch_decode.sv
// hex fetch/prefix-decode stage: fetches words, walks bytes, folds PFIX/NFIX
// into a 32-bit operand and hands completed instructions to execute.
module hex_fetch_decode #(
    parameter logic [17:0] RESET_PC = 18'd0
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req_valid,
    output logic [15:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    input  logic        redirect_valid,
    input  logic [17:0] redirect_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [3:0]  dec_opc,
    output logic [31:0] dec_opd,
    output logic [17:0] dec_pc,
    output logic [17:0] dec_next_pc,
    output logic        dec_illegal
);

    localparam logic [3:0] OPC_PFIX = 4'hD;
    localparam logic [3:0] OPC_NFIX = 4'hE;
    localparam logic [3:0] OPC_ILL  = 4'hF;

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_DECODE,
        S_HOLD
    } state_t;

    state_t      state_q;
    logic [17:0] pc_q;
    logic [31:0] oreg_q;
    logic [31:0] buf_q;
    logic        drop_q;
    logic        req_q;
    logic [15:0] addr_q;
    logic        dvalid_q;
    logic [3:0]  dopc_q;
    logic [31:0] dopd_q;
    logic [17:0] dpc_q;
    logic [17:0] dnpc_q;
    logic        dill_q;

    logic [7:0]  byte_d;
    logic [3:0]  opc_d;
    logic [31:0] opd_d;
    logic [17:0] pc_inc_d;
    logic        is_pfx_d;
    logic        busy_d;

    assign byte_d   = buf_q[{pc_q[1:0], 3'b000} +: 8];
    assign opc_d    = byte_d[7:4];
    assign opd_d    = oreg_q | {28'd0, byte_d[3:0]};
    assign pc_inc_d = pc_q + 18'd1;
    assign is_pfx_d = (opc_d == OPC_PFIX) || (opc_d == OPC_NFIX);

    // A read is still in flight after this edge unless its data lands now.
    assign busy_d = ((state_q == S_WAIT) || (state_q == S_FETCH && drop_q))
                    && !mem_rsp_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            oreg_q   <= '0;
            buf_q    <= '0;
            drop_q   <= busy_d;
            req_q    <= 1'b0;
            addr_q   <= '0;
            dvalid_q <= 1'b0;
            dopc_q   <= '0;
            dopd_q   <= '0;
            dpc_q    <= '0;
            dnpc_q   <= '0;
            dill_q   <= 1'b0;
        end else if (redirect_valid) begin
            pc_q     <= redirect_pc;
            oreg_q   <= '0;
            dvalid_q <= 1'b0;
            if (busy_d) begin
                drop_q  <= 1'b1;
                req_q   <= 1'b0;
                state_q <= S_FETCH;
            end else begin
                // Nothing in flight: the new fetch leaves on the next cycle.
                drop_q  <= 1'b0;
                req_q   <= 1'b1;
                addr_q  <= redirect_pc[17:2];
                state_q <= S_WAIT;
            end
        end else begin
            req_q <= 1'b0;
            unique case (state_q)
                S_FETCH: begin
                    if (!drop_q || mem_rsp_valid) begin
                        drop_q  <= 1'b0;
                        req_q   <= 1'b1;
                        addr_q  <= pc_q[17:2];
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_rsp_valid) begin
                        buf_q   <= mem_rsp_data;
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    pc_q <= pc_inc_d;
                    if (is_pfx_d) begin
                        if (opc_d == OPC_NFIX) begin
                            oreg_q <= 32'hFFFF_FF00 | (opd_d << 4);
                        end else begin
                            oreg_q <= opd_d << 4;
                        end
                        if (pc_q[1:0] == 2'd3) begin
                            state_q <= S_FETCH;
                        end
                    end else begin
                        dvalid_q <= 1'b1;
                        dopc_q   <= opc_d;
                        dopd_q   <= opd_d;
                        dpc_q    <= pc_q;
                        dnpc_q   <= pc_inc_d;
                        dill_q   <= (opc_d == OPC_ILL);
                        oreg_q   <= '0;
                        state_q  <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (dec_ready) begin
                        dvalid_q <= 1'b0;
                        if (pc_q[1:0] == 2'd0) begin
                            state_q <= S_FETCH;
                        end else begin
                            state_q <= S_DECODE;
                        end
                    end
                end
                default: state_q <= S_FETCH;
            endcase
        end
    end

    assign mem_req_valid = req_q;
    assign mem_req_addr  = addr_q;
    assign dec_valid     = dvalid_q;
    assign dec_opc       = dopc_q;
    assign dec_opd       = dopd_q;
    assign dec_pc        = dpc_q;
    assign dec_next_pc   = dnpc_q;
    assign dec_illegal   = dill_q;

endmodule

// File: doc/hex_fetch_decode.md
# hex_fetch_decode

Instruction fetch and prefix-decode stage of the hex processor. Fetches 32-bit words from instruction memory, steps through them one 8-bit instruction at a time, and folds PFIX/NFIX sequences into a full 32-bit operand register. Only completed, non-prefix instructions go to the execute stage, over a valid/ready handshake. Execute feeds branch targets back through a redirect port.

## Interface

- `RESET_PC`, default 0: byte address of the first instruction after reset, `MEM_ADDR_WIDTH` (18) bits.
- `clk`, in, 1: the single clock.
- `rst`, in, 1: reset. Synchronous, active-high.
- `mem_req_valid`, out, 1: word read request. Memory always accepts it.
- `mem_req_addr`, out, 16: word address (`waddr_t`, byte address bits [17:2]).
- `mem_rsp_valid`, in, 1: read data valid. Arrives 1 or more cycles after the request. At most one request is outstanding.
- `mem_rsp_data`, in, 32: read word.
- `redirect_valid`, in, 1: branch/restart request from execute.
- `redirect_pc`, in, 18: new byte address.
- `dec_valid`, out, 1: decoded instruction available.
- `dec_ready`, in, 1: execute accepts it.
- `dec_opc`, out, 4: opcode (`opc_t`).
- `dec_opd`, out, 32: full operand (oreg OR low nibble).
- `dec_pc`, out, 18: byte address of the final (non-prefix) byte.
- `dec_next_pc`, out, 18: `dec_pc`+1, mod 2^18.
- `dec_illegal`, out, 1: opcode is 15 (undefined).

## Operation

- Byte k of a word occupies bits [8k+7:8k], selected by pc[1:0]. Opcode is bits [7:4], operand nibble is bits [3:0].
- State machine has four states:
  - **FETCH**: assert `mem_req_valid` for exactly 1 cycle with `mem_req_addr` = pc[17:2], then go to WAIT.
  - **WAIT**: on `mem_rsp_valid`, latch the word into the buffer, go to DECODE.
  - **DECODE**: process one byte per cycle, computing t = oreg | nibble.
    - PFIX: oreg ← t<<4.
    - NFIX: oreg ← 32'hFFFFFF00 | (t<<4).
    - Any other opcode: register the `dec_*` outputs with `dec_opd` = t, clear oreg, go to HOLD.
    - In every case pc ← pc+1. If the consumed byte was byte 3, a prefix byte goes to FETCH instead of staying in DECODE. oreg persists across word boundaries.
  - **HOLD**: `dec_valid` high, outputs stable. On `dec_valid && dec_ready`, go to FETCH if pc[1:0]==0, else DECODE.
- Opcode 15 is emitted like any non-prefix instruction with `dec_illegal`=1. It does not clear decode state beyond the normal oreg clear.
- pc wraps from 2^18−1 to 0.
- **Redirect** has priority over everything else in the same cycle:
  - Next state: pc ← `redirect_pc`, oreg ← 0, buffer invalid, `dec_valid` ← 0, state FETCH.
  - If a request is outstanding, set a drop flag. The matching response is discarded and the new request issues only after that response arrives. There is never more than one outstanding request.
  - A handshake completing in the same cycle as a redirect counts as accepted.
- **Reset**:
  - All outputs 0, except `dec_next_pc` = 0.
  - pc = `RESET_PC`, oreg = 0, drop flag = 0, state FETCH.
  - Any response arriving after reset from a pre-reset request is discarded: the drop flag is set if reset hits in WAIT.

## Timing

- Reset deasserts at cycle 0. `mem_req_valid` is high at cycle 1.
- With 1-cycle memory, the response arrives at cycle 2, DECODE runs at cycle 3, and `dec_valid` rises at cycle 4.
- Each prefix byte adds 1 cycle.
- A same-word next instruction: `dec_valid` is high again 2 cycles after the handshake (DECODE, then HOLD).
- Word boundary crossing adds FETCH + memory latency + 1 cycle.
- `dec_*` outputs are registered and held constant while `dec_valid && !dec_ready`.
- No fetch is issued while in HOLD. No prefetch.
- Redirect asserted at cycle n, no outstanding request: `mem_req_valid` at n+1 with the new address.

## Test plan

- **Single instruction.** Word 0 = 0x00000031, `RESET_PC`=0, 1-cycle memory.
  - Expect one request, address 0.
  - Expect `dec_valid` at cycle 4 with opc=3, opd=1, pc=0, next_pc=1.
- **Positive prefix.** Bytes 0..2 = D1 D2 33.
  - Expect a single output: opc=3, opd=0x123, pc=2.
  - Expect no `dec_valid` for the prefix bytes.
- **Negative prefix.** Bytes EF 3F.
  - Expect opc=3, opd=0xFFFFFFFF, pc=1.
- **Prefix across a word boundary.** Word 0 byte 3 = D1, word 1 byte 0 = 32, `RESET_PC`=3.
  - Expect requests to addresses 0 then 1.
  - Expect output opc=3, opd=0x12, pc=4.
- **Redirect during WAIT.** 3-cycle memory; redirect to 0x100 one cycle after the request.
  - Expect the old response ignored.
  - Expect the next request to address 0x40, issued after the old response.
  - Expect the first output at pc=0x100 with oreg cleared.
- **Backpressure and illegal opcode.** Bytes 31 F0; `dec_ready` held low 5 cycles.
  - Expect the first output stable for all 5 cycles and no memory request.
  - Then expect opc=15, `dec_illegal`=1, pc=1.
